// File: rtl/ps2_keyboard_decoder_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard decoder and
// the game-logic consumer.
package ps2_keyboard_decoder_pkg;

   typedef enum logic [2:0] {
      OP_W     = 3'b000,
      OP_A     = 3'b001,
      OP_S     = 3'b010,
      OP_D     = 3'b011,
      OP_SPACE = 3'b100,
      OP_Z     = 3'b101,
      OP_NONE  = 3'b110
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BREAK,
      ST_EXT,
      ST_EXT_BREAK
   } dec_state_e;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_Z     = 8'h1A;

   // Set-2 make code to game operation; anything else maps to OP_NONE.
   function automatic op_e key_to_op(input logic [7:0] code);
      op_e op;
      case (code)
         SC_W:     op = OP_W;
         SC_A:     op = OP_A;
         SC_S:     op = OP_S;
         SC_D:     op = OP_D;
         SC_SPACE: op = OP_SPACE;
         SC_Z:     op = OP_Z;
         default:  op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ps2_keyboard_decoder_frame_receiver.sv
// PS/2 frame receiver: synchronizes the raw PS/2 lines, shifts in 11-bit
// frames on falling ps2_clock edges and reports good bytes or frame errors.
module ps2_frame_receiver #(
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int LOG2_TIMEOUT   = 18
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       frame_error_o
);

   localparam logic [LOG2_TIMEOUT-1:0] TIMEOUT_LIM = LOG2_TIMEOUT'(TIMEOUT_CYCLES);

   logic [1:0]              clk_sync_q;
   logic [1:0]              dat_sync_q;
   logic                    clk_prev_q;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic [8:0]              shift_q, shift_d;
   logic [LOG2_TIMEOUT-1:0] to_cnt_q, to_cnt_d;
   logic                    valid_q, valid_d;
   logic [7:0]              byte_q, byte_d;
   logic                    err_q, err_d;
   logic                    fall;
   logic                    ps2_bit;
   logic                    timed_out;

   assign fall      = clk_prev_q & ~clk_sync_q[1];
   assign ps2_bit   = dat_sync_q[1];
   assign timed_out = (to_cnt_q == TIMEOUT_LIM) && (bit_cnt_q != 4'd0);

   // Two-flop synchronizers plus the previous-cycle copy for edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clock};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
         clk_prev_q <= clk_sync_q[1];
      end
   end

   // Frame sequencing: start check, 9-bit shift (data + parity), stop/parity check, timeout.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      to_cnt_d  = (to_cnt_q == TIMEOUT_LIM) ? to_cnt_q : to_cnt_q + 1'b1;
      if (fall) begin
         to_cnt_d = '0;
         if (bit_cnt_q == 4'd0) begin
            if (!ps2_bit) bit_cnt_d = 4'd1;
            else          err_d     = 1'b1;
         end else if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            if (ps2_bit && (^shift_q)) begin
               valid_d = 1'b1;
               byte_d  = shift_q[7:0];
            end else begin
               err_d = 1'b1;
            end
         end else begin
            shift_d   = {ps2_bit, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (timed_out) begin
         bit_cnt_d = 4'd0;
         err_d     = 1'b1;
      end
   end

   // Frame state registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         to_cnt_q  <= '0;
         valid_q   <= 1'b0;
         byte_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         to_cnt_q  <= to_cnt_d;
         valid_q   <= valid_d;
         byte_q    <= byte_d;
         err_q     <= err_d;
      end
   end

   assign byte_valid_o  = valid_q;
   assign byte_o        = byte_q;
   assign frame_error_o = err_q;

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard decoder: turns set-2 scan codes into one-at-a-time game
// operations with a ready/read_fin handshake and a one-deep pending slot.
//
// state        | meaning
// ST_IDLE      | waiting for a make code or a prefix
// ST_BREAK     | F0 seen; next byte is a released key
// ST_EXT       | E0 seen; extended key, ignored
// ST_EXT_BREAK | E0 F0 seen; next byte is swallowed
module ps2_keyboard_decoder
   import ps2_keyboard_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int LOG2_TIMEOUT   = 18,
   parameter int REPEAT_FILTER  = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   input  logic       keyboard_read_fin,
   output logic       keyboard_ready,
   output logic [2:0] keyboard_data,
   output logic [7:0] scancode_o_test,
   output logic       frame_error_o_test
);

   logic       byte_valid;
   logic [7:0] rx_byte;
   logic       frame_err;

   dec_state_e state_q, state_d;
   logic [7:0] held_q, held_d;
   logic       emit;
   op_e        emit_op;
   logic       ready_q, ready_d;
   op_e        data_q, data_d;
   logic       pend_vld_q, pend_vld_d;
   op_e        pend_op_q, pend_op_d;

   ps2_frame_receiver #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .LOG2_TIMEOUT   (LOG2_TIMEOUT)
   ) u_rx (
      .clock         (clock),
      .reset         (reset),
      .ps2_clock     (ps2_clock),
      .ps2_data      (ps2_data),
      .byte_valid_o  (byte_valid),
      .byte_o        (rx_byte),
      .frame_error_o (frame_err)
   );

   // Decode state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Prefix tracking; a bad frame drops any half-seen prefix.
   always_comb begin
      state_d = state_q;
      if (frame_err) begin
         state_d = ST_IDLE;
      end else if (byte_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == SC_BREAK)     state_d = ST_BREAK;
               else if (rx_byte == SC_EXT)  state_d = ST_EXT;
            end
            ST_EXT:  state_d = (rx_byte == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Emit decision and held-key bookkeeping for the repeat filter.
   always_comb begin
      emit    = 1'b0;
      emit_op = OP_NONE;
      held_d  = held_q;
      if (byte_valid && !frame_err) begin
         case (state_q)
            ST_IDLE: begin
               if (key_to_op(rx_byte) != OP_NONE) begin
                  if (!((REPEAT_FILTER != 0) && (rx_byte == held_q))) begin
                     emit    = 1'b1;
                     emit_op = key_to_op(rx_byte);
                  end
                  held_d = rx_byte;
               end
            end
            ST_BREAK: begin
               if (rx_byte == held_q) held_d = '0;
            end
            default: ;
         endcase
      end
   end

   // Handshake: acknowledge first, then promote pending, then place the new emit.
   always_comb begin
      ready_d    = ready_q;
      data_d     = data_q;
      pend_vld_d = pend_vld_q;
      pend_op_d  = pend_op_q;
      if (ready_q && keyboard_read_fin) begin
         ready_d = 1'b0;
         data_d  = OP_NONE;
      end
      if (pend_vld_q && !ready_d && !keyboard_read_fin) begin
         ready_d    = 1'b1;
         data_d     = pend_op_q;
         pend_vld_d = 1'b0;
      end
      if (emit) begin
         if (!ready_d && !pend_vld_d && !keyboard_read_fin) begin
            ready_d = 1'b1;
            data_d  = emit_op;
         end else if (!pend_vld_d) begin
            pend_vld_d = 1'b1;
            pend_op_d  = emit_op;
         end
      end
   end

   // Held key and handshake registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         held_q     <= '0;
         ready_q    <= 1'b0;
         data_q     <= OP_NONE;
         pend_vld_q <= 1'b0;
         pend_op_q  <= OP_NONE;
      end else begin
         held_q     <= held_d;
         ready_q    <= ready_d;
         data_q     <= data_d;
         pend_vld_q <= pend_vld_d;
         pend_op_q  <= pend_op_d;
      end
   end

   assign keyboard_ready     = ready_q;
   assign keyboard_data      = data_q;
   assign scancode_o_test    = rx_byte;
   assign frame_error_o_test = frame_err;

endmodule
